// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of the single-issue core. It holds the program
// counter and presents it to a combinational instruction memory. The word
// that comes back is registered into the IF/ID pipeline register for the
// decoder. The stage supports decode-side stalls and branch/jump redirects,
// which flush IF/ID. It halts permanently, until reset, on an illegal fetch
// address.
//
// Parameters
//   RESET_VECTOR      PC loaded on reset (must be word aligned)
//   MEMORY_SIZE       instruction memory size in bytes; PC >= size faults
//   NOP_INSTRUCTION   word held in IF/ID after reset or flush
//
// Ports
//   clk                in   rising-edge clock
//   reset              in   synchronous, active-low reset
//   imem_address       out  byte address to instruction memory (= PC)
//   imem_data          in   instruction word for imem_address (combinational)
//   stall              in   decoder cannot accept; hold PC and IF/ID
//   redirect_valid     in   taken branch/jump this cycle
//   redirect_target    in   new PC when redirect_valid is high
//   if_id_valid        out  IF/ID holds a real instruction
//   if_id_pc           out  address of if_id_instruction
//   if_id_pc_plus4     out  if_id_pc + 4 (mod 2^32)
//   if_id_instruction  out  fetched word
//   fetch_fault        out  unit halted on a bad address (sticky)
//   fault_address      out  address that caused the fault
//   fetch_count        out  instructions delivered, wraps at 2^32
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
   parameter logic [31:0] MEMORY_SIZE     = 32'd1024,
   parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instruction,
   output logic        fetch_fault,
   output logic [31:0] fault_address,
   output logic [31:0] fetch_count
);

   typedef enum logic {
      FETCH  = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic        target_bad;
   logic        pc_bad;

   // The memory reads straight from the PC register, so the address is
   // stable for the whole cycle and the returned word is captured on the
   // next edge.
   assign imem_address = pc_reg;

   // A redirect target must be word aligned and inside the memory. The
   // sequential PC is always aligned, so only its range needs checking.
   assign target_bad = (redirect_target[1:0] != 2'b00) ||
                       (redirect_target >= MEMORY_SIZE);
   assign pc_bad     = (pc_reg >= MEMORY_SIZE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg         <= FETCH;
         pc_reg            <= RESET_VECTOR;
         if_id_valid       <= 1'b0;
         if_id_pc          <= 32'h0;
         if_id_pc_plus4    <= 32'h0;
         if_id_instruction <= NOP_INSTRUCTION;
         fetch_fault       <= 1'b0;
         fault_address     <= 32'h0;
         fetch_count       <= 32'h0;
      end else begin
         case (state_reg)
            FETCH: begin
               if (redirect_valid) begin
                  // A redirect overrides a simultaneous stall: the
                  // instruction sitting in IF/ID belongs to the wrong path
                  // whether or not the decoder could take it.
                  if (target_bad) begin
                     state_reg         <= HALTED;
                     fetch_fault       <= 1'b1;
                     fault_address     <= redirect_target;
                     if_id_valid       <= 1'b0;
                     if_id_instruction <= NOP_INSTRUCTION;
                  end else begin
                     pc_reg            <= redirect_target;
                     if_id_valid       <= 1'b0;
                     if_id_instruction <= NOP_INSTRUCTION;
                  end
               end else if (!stall) begin
                  if (pc_bad) begin
                     state_reg         <= HALTED;
                     fetch_fault       <= 1'b1;
                     fault_address     <= pc_reg;
                     if_id_valid       <= 1'b0;
                     if_id_instruction <= NOP_INSTRUCTION;
                  end else begin
                     if_id_pc          <= pc_reg;
                     if_id_pc_plus4    <= pc_reg + 32'd4;
                     if_id_instruction <= imem_data;
                     if_id_valid       <= 1'b1;
                     pc_reg            <= pc_reg + 32'd4;
                     fetch_count       <= fetch_count + 32'd1;
                  end
               end
               // Stall without redirect: everything holds.
            end
            HALTED: begin
               // Frozen until reset; stall and redirect are ignored.
            end
            default: state_reg <= HALTED;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed steps followed by a randomized phase. Every cycle, each DUT output
// is compared against a behavioural model of the fetch stage kept in this
// file. The memory is 256 bytes, so the in-range and out-of-range boundaries
// are easy to reach.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] RV   = 32'h0000_0000;
   localparam logic [31:0] MEM  = 32'd256;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_address;
   logic [31:0] imem_data;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instruction;
   logic        fetch_fault;
   logic [31:0] fault_address;
   logic [31:0] fetch_count;

   fetch_unit #(
      .RESET_VECTOR    (RV),
      .MEMORY_SIZE     (MEM),
      .NOP_INSTRUCTION (NOP)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .imem_address      (imem_address),
      .imem_data         (imem_data),
      .stall             (stall),
      .redirect_valid    (redirect_valid),
      .redirect_target   (redirect_target),
      .if_id_valid       (if_id_valid),
      .if_id_pc          (if_id_pc),
      .if_id_pc_plus4    (if_id_pc_plus4),
      .if_id_instruction (if_id_instruction),
      .fetch_fault       (fetch_fault),
      .fault_address     (fault_address),
      .fetch_count       (fetch_count)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: 64 words.
   logic [31:0] mem [0:63];

   function automatic logic [31:0] word_at(input logic [31:0] addr);
      if (addr < MEM) return mem[addr[7:2]];
      return 32'hDEAD_BEEF;
   endfunction

   always_comb imem_data = word_at(imem_address);

   // Behavioural model state.
   logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_faddr, m_count;
   bit          m_valid, m_fault, m_halted;

   int passed = 0;
   int total  = 0;

   task automatic model_step(input bit rst_n, input bit st, input bit rv,
                             input logic [31:0] rt);
      if (!rst_n) begin
         m_pc = RV; m_valid = 0; m_ipc = 0; m_ipc4 = 0; m_instr = NOP;
         m_fault = 0; m_faddr = 0; m_count = 0; m_halted = 0;
      end else if (!m_halted) begin
         if (rv) begin
            if ((rt % 4) != 0 || rt >= MEM) begin
               m_halted = 1; m_fault = 1; m_faddr = rt;
               m_valid = 0; m_instr = NOP;
            end else begin
               m_pc = rt; m_valid = 0; m_instr = NOP;
            end
         end else if (!st) begin
            if (m_pc >= MEM) begin
               m_halted = 1; m_fault = 1; m_faddr = m_pc;
               m_valid = 0; m_instr = NOP;
            end else begin
               m_ipc   = m_pc;
               m_ipc4  = m_pc + 32'd4;
               m_instr = word_at(m_pc);
               m_valid = 1;
               m_pc    = m_pc + 32'd4;
               m_count = m_count + 32'd1;
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic compare_all();
      check("imem_address", imem_address, m_pc);
      check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
      check("if_id_pc", if_id_pc, m_ipc);
      check("if_id_pc_plus4", if_id_pc_plus4, m_ipc4);
      check("if_id_instruction", if_id_instruction, m_instr);
      check("fetch_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
      check("fault_address", fault_address, m_faddr);
      check("fetch_count", fetch_count, m_count);
   endtask

   // One clock: drive inputs on the falling edge, advance the model, then
   // sample 1 ns after the rising edge.
   task automatic cycle(input bit rst_n, input bit st, input bit rv,
                        input logic [31:0] rt);
      @(negedge clk);
      reset = rst_n; stall = st; redirect_valid = rv; redirect_target = rt;
      model_step(rst_n, st, rv, rt);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h00A0_0113;

      // Reset while a stall and a redirect are both requested.
      cycle(0, 1, 1, 32'h40);
      check("reset_instr_nop", if_id_instruction, 32'h0000_0013);

      // First two sequential fetches.
      cycle(1, 0, 0, 0);
      check("first_instr", if_id_instruction, 32'h0050_0093);
      check("first_pc", if_id_pc, 32'h0);
      cycle(1, 0, 0, 0);
      check("second_instr", if_id_instruction, 32'h00A0_0113);
      check("second_count", fetch_count, 32'd2);

      // Three stalled cycles at PC=0x8, then release.
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 0, 0);
         check("stall_addr", imem_address, 32'h8);
      end
      cycle(1, 0, 0, 0);
      check("post_stall_pc", if_id_pc, 32'h8);

      // Redirect wins over a simultaneous stall.
      cycle(1, 1, 1, 32'h40);
      check("redir_addr", imem_address, 32'h40);
      check("redir_bubble", {31'h0, if_id_valid}, 32'h0);
      cycle(1, 0, 0, 0);
      check("redir_target_pc", if_id_pc, 32'h40);

      // Unaligned redirect halts; later inputs are ignored.
      cycle(1, 0, 1, 32'h42);
      check("unaligned_faddr", fault_address, 32'h42);
      cycle(1, 0, 1, 32'h0);
      cycle(1, 1, 0, 0);
      cycle(1, 0, 0, 0);
      check("halted_addr", imem_address, 32'h44);

      // Reset out of HALTED.
      cycle(0, 0, 0, 0);
      check("reset_clears_fault", {31'h0, fetch_fault}, 32'h0);

      // Redirect to exactly MEMORY_SIZE faults.
      cycle(1, 0, 1, MEM);
      check("redir_limit_fault", {31'h0, fetch_fault}, 32'h1);
      cycle(0, 0, 0, 0);

      // Run sequentially off the end of memory.
      cycle(1, 0, 1, MEM - 32'd8);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      check("last_word_pc", if_id_pc, MEM - 32'd4);
      cycle(1, 0, 0, 0);
      check("seq_fault_addr", fault_address, MEM);
      check("seq_fault_count", fetch_count, 32'd2);
      cycle(0, 0, 0, 0);

      // Randomized phase.
      for (int i = 0; i < 600; i++) begin
         bit          rn, st, rv;
         logic [31:0] t;
         int unsigned k;
         rn = ($urandom_range(0, 99) >= 3);
         if (m_halted && $urandom_range(0, 4) == 0) rn = 0;
         st = ($urandom_range(0, 3) == 0);
         rv = ($urandom_range(0, 6) == 0);
         k  = $urandom_range(0, 11);
         if (k == 0)      t = $urandom;
         else if (k == 1) t = 32'($urandom_range(0, 63)) * 32'd4 + 32'd2;
         else             t = 32'($urandom_range(0, 63)) * 32'd4;
         cycle(rn, st, rv, t);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
